vid_timing_gen: RTL and testbench

- Parametrised raster timing generator for the HDMI/DVI output path, single pixel-clock domain.
- Produces pixel-fetch requests (o_rd with x/y) a configurable number of cycles ahead of the aligned control outputs o_de, o_hsync and o_vsync.
- The lead covers the latency of the framebuffer/pattern source, so the TMDS encoders get data and control in the same cycle.
- Adds run-time stall (i_en), configurable sync polarity and a frame counter.

---
 rtl/vid_timing_gen_if.sv | 41 ++++
 rtl/vid_timing_gen.sv | 155 +++++++++++++++
 tb/tb_vid_timing_gen.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vid_timing_gen_if.sv
// Raster output bundle of vid_timing_gen.
// Early pixel request plus aligned de/sync lines.
interface vid_timing_gen_if #(
  parameter int CW = 12
);

  logic          o_rd;
  logic [CW-1:0] o_x;
  logic [CW-1:0] o_y;
  logic          o_newline;
  logic          o_newframe;
  logic          o_de;
  logic          o_hsync;
  logic          o_vsync;
  logic [15:0]   o_frame;

  modport master (
    output o_rd,
    output o_x,
    output o_y,
    output o_newline,
    output o_newframe,
    output o_de,
    output o_hsync,
    output o_vsync,
    output o_frame
  );

  modport slave (
    input o_rd,
    input o_x,
    input o_y,
    input o_newline,
    input o_newframe,
    input o_de,
    input o_hsync,
    input o_vsync,
    input o_frame
  );

endinterface

// File: rtl/vid_timing_gen.sv
// Raster timing generator for the HDMI/DVI path.
// Requests lead de/hsync/vsync by RD_LEAD cycles.
module vid_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1,
  parameter int RD_LEAD  = 1,
  parameter int CW       = 12
) (
  input  logic                   i_pixclk,
  input  logic                   i_reset_n,
  input  logic                   i_en,
  vid_timing_gen_if.master       vo
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = V_ACTIVE + V_FP + V_SYNC;

  localparam logic HS_ON  = HS_POL[0];
  localparam logic VS_ON  = VS_POL[0];

  logic [CW-1:0] cx;
  logic [CW-1:0] cy;
  logic [CW-1:0] x_q;
  logic [CW-1:0] y_q;
  logic          rd_q;
  logic          nl_q;
  logic          nf_q;
  logic [15:0]   frame_q;

  logic          x_end;
  logic          y_end;
  logic          act;
  logic          hs;
  logic          vs;
  logic          lx;
  logic          ly;
  logic [2:0]    tap;

  logic          de_q;
  logic          hs_q;
  logic          vs_q;

  // Raster position decodes shared by both stages
  always_comb begin
    x_end = int'(cx) == H_TOTAL - 1;
    y_end = int'(cy) == V_TOTAL - 1;
    act   = (int'(cx) < H_ACTIVE) &&
            (int'(cy) < V_ACTIVE);
    hs    = (int'(cx) >= HS_BEG) &&
            (int'(cx) < HS_END);
    vs    = (int'(cy) >= VS_BEG) &&
            (int'(cy) < VS_END);
    lx    = int'(cx) == H_ACTIVE - 1;
    ly    = int'(cy) == V_ACTIVE - 1;
  end

  // Pixel/line counters, wrap to (0,0) in one step
  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cx <= '0;
      cy <= '0;
    end else if (i_en) begin
      if (x_end) begin
        cx <= '0;
        cy <= y_end ? '0 : cy + 1'b1;
      end else begin
        cx <= cx + 1'b1;
      end
    end
  end

  // Request stage: what the pixel source fetches next
  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_q <= 1'b0;
      nl_q <= 1'b0;
      nf_q <= 1'b0;
      x_q  <= '0;
      y_q  <= '0;
    end else if (i_en) begin
      rd_q <= act;
      nl_q <= act && lx;
      nf_q <= act && lx && ly;
      x_q  <= cx;
      y_q  <= cy;
    end
  end

  // Completed-frame count, bumps on the last pixel request
  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      frame_q <= '0;
    end else if (i_en && nf_q) begin
      frame_q <= frame_q + 16'd1;
    end
  end

  if (RD_LEAD == 0) begin : g_nodl
    assign tap = {act, hs, vs};
  end else begin : g_dl
    logic [2:0] dl [RD_LEAD];

    // Control delay line covering the source latency
    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        for (int i = 0; i < RD_LEAD; i++) begin
          dl[i] <= '0;
        end
      end else if (i_en) begin
        dl[0] <= {act, hs, vs};
        for (int i = 1; i < RD_LEAD; i++) begin
          dl[i] <= dl[i-1];
        end
      end
    end

    assign tap = dl[RD_LEAD-1];
  end

  // Output register drives sync at its asserted level
  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      de_q <= 1'b0;
      hs_q <= ~HS_ON;
      vs_q <= ~VS_ON;
    end else if (i_en) begin
      de_q <= tap[2];
      hs_q <= tap[1] ? HS_ON : ~HS_ON;
      vs_q <= tap[0] ? VS_ON : ~VS_ON;
    end
  end

  assign vo.o_rd       = rd_q & i_en;
  assign vo.o_newline  = nl_q & i_en;
  assign vo.o_newframe = nf_q & i_en;
  assign vo.o_x        = x_q;
  assign vo.o_y        = y_q;
  assign vo.o_de       = de_q;
  assign vo.o_hsync    = hs_q;
  assign vo.o_vsync    = vs_q;
  assign vo.o_frame    = frame_q;

endmodule

// File: tb/tb_vid_timing_gen.sv
// Self-checking bench for vid_timing_gen.
// Four configs checked against an arithmetic raster model.
module tb_vid_timing_gen;

  typedef struct packed {
    int ha;
    int hfp;
    int hsw;
    int hbp;
    int va;
    int vfp;
    int vsw;
    int vbp;
    int lead;
    bit hpol;
    bit vpol;
  } cfg_t;

  typedef struct {
    int n;
    int x;
    int y;
  } req_t;

  localparam cfg_t C0 = '{ha:640, hfp:16, hsw:96, hbp:48,
                          va:480, vfp:10, vsw:2, vbp:33,
                          lead:1, hpol:1'b1, vpol:1'b1};
  localparam cfg_t C1 = '{ha:16, hfp:2, hsw:3, hbp:3,
                          va:4, vfp:1, vsw:1, vbp:1,
                          lead:4, hpol:1'b1, vpol:1'b1};
  localparam cfg_t C2 = '{ha:16, hfp:2, hsw:3, hbp:3,
                          va:4, vfp:1, vsw:1, vbp:1,
                          lead:0, hpol:1'b0, vpol:1'b0};
  localparam cfg_t C3 = '{ha:1, hfp:0, hsw:0, hbp:0,
                          va:1, vfp:0, vsw:0, vbp:0,
                          lead:1, hpol:1'b1, vpol:1'b1};

  logic clk = 1'b0;
  logic r0 = 1'b0;
  logic r1 = 1'b0;
  logic r2 = 1'b0;
  logic r3 = 1'b0;
  logic e0 = 1'b1;
  logic e1 = 1'b1;
  logic e2 = 1'b1;
  logic e3 = 1'b1;

  int checks = 0;
  int failures = 0;
  int n3 = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (r3 && e3) n3 <= n3 + 1;
  end

  vid_timing_gen_if #(.CW(12)) v0 ();
  vid_timing_gen_if #(.CW(12)) v1 ();
  vid_timing_gen_if #(.CW(12)) v2 ();
  vid_timing_gen_if #(.CW(4))  v3 ();

  vid_timing_gen d0 (
    .i_pixclk (clk),
    .i_reset_n(r0),
    .i_en     (e0),
    .vo       (v0)
  );

  vid_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1), .VS_POL(1), .RD_LEAD(4), .CW(12)
  ) d1 (
    .i_pixclk (clk),
    .i_reset_n(r1),
    .i_en     (e1),
    .vo       (v1)
  );

  vid_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .RD_LEAD(0), .CW(12)
  ) d2 (
    .i_pixclk (clk),
    .i_reset_n(r2),
    .i_en     (e2),
    .vo       (v2)
  );

  vid_timing_gen #(
    .H_ACTIVE(1), .H_FP(0), .H_SYNC(0), .H_BP(0),
    .V_ACTIVE(1), .V_FP(0), .V_SYNC(0), .V_BP(0),
    .HS_POL(1), .VS_POL(1), .RD_LEAD(1), .CW(4)
  ) d3 (
    .i_pixclk (clk),
    .i_reset_n(r3),
    .i_en     (e3),
    .vo       (v3)
  );

  // Expected outputs after n enabled edges since reset release.
  function automatic logic [45:0] model(cfg_t c, int n, bit en);
    int ht, vt, tot, p, x, y, q, qx, qy, last, fr;
    bit a, rd, nl, nf, de, hl, vl;
    ht = c.ha + c.hfp + c.hsw + c.hbp;
    vt = c.va + c.vfp + c.vsw + c.vbp;
    tot = ht * vt;
    x = 0; y = 0; fr = 0;
    rd = 0; nl = 0; nf = 0; de = 0;
    hl = !c.hpol;
    vl = !c.vpol;
    if (n >= 1) begin
      p = (n - 1) % tot;
      x = p % ht;
      y = p / ht;
      a = (x < c.ha) && (y < c.va);
      rd = en && a;
      nl = rd && (x == c.ha - 1);
      nf = nl && (y == c.va - 1);
    end
    if (n >= c.lead + 1) begin
      q = (n - 1 - c.lead) % tot;
      qx = q % ht;
      qy = q / ht;
      de = (qx < c.ha) && (qy < c.va);
      if (qx >= c.ha + c.hfp && qx < c.ha + c.hfp + c.hsw)
        hl = c.hpol;
      if (qy >= c.va + c.vfp && qy < c.va + c.vfp + c.vsw)
        vl = c.vpol;
    end
    last = (c.va - 1) * ht + c.ha - 1;
    if (n - 2 >= last) fr = (n - 2 - last) / tot + 1;
    return {rd, nl, nf, de, hl, vl, 12'(x), 12'(y), 16'(fr)};
  endfunction

  function automatic logic [45:0] act0();
    return {v0.o_rd, v0.o_newline, v0.o_newframe, v0.o_de,
            v0.o_hsync, v0.o_vsync, v0.o_x, v0.o_y, v0.o_frame};
  endfunction

  function automatic logic [45:0] act1();
    return {v1.o_rd, v1.o_newline, v1.o_newframe, v1.o_de,
            v1.o_hsync, v1.o_vsync, v1.o_x, v1.o_y, v1.o_frame};
  endfunction

  function automatic logic [45:0] act2();
    return {v2.o_rd, v2.o_newline, v2.o_newframe, v2.o_de,
            v2.o_hsync, v2.o_vsync, v2.o_x, v2.o_y, v2.o_frame};
  endfunction

  function automatic logic [45:0] act3();
    return {v3.o_rd, v3.o_newline, v3.o_newframe, v3.o_de,
            v3.o_hsync, v3.o_vsync, 12'(v3.o_x), 12'(v3.o_y),
            v3.o_frame};
  endfunction

  task automatic test_reset();
    logic [45:0] g, x;
    r0 = 0; r1 = 0; r2 = 0; r3 = 0;
    e0 = 1; e1 = 1; e2 = 1; e3 = 1;
    repeat (3) @(negedge clk);
    #1;
    g = act0(); x = model(C0, 0, 1'b1);
    checks++;
    if (g !== x) begin
      failures++;
      $display("FAIL reset_d0 got=%h exp=%h", g, x);
    end
    g = act1(); x = model(C1, 0, 1'b1);
    checks++;
    if (g !== x) begin
      failures++;
      $display("FAIL reset_d1 got=%h exp=%h", g, x);
    end
    g = act2(); x = model(C2, 0, 1'b1);
    checks++;
    if (g !== x) begin
      failures++;
      $display("FAIL reset_d2 got=%h exp=%h", g, x);
    end
    checks++;
    if ({v2.o_hsync, v2.o_vsync} !== 2'b11) begin
      failures++;
      $display("FAIL reset_idle_pol0 got=%b exp=11",
               {v2.o_hsync, v2.o_vsync});
    end
    @(negedge clk);
    r3 = 1;
  endtask

  task automatic test_first_line();
    logic [45:0] g, x;
    int nrd = 0, nnl = 0, nde = 0, nhs = 0;
    @(negedge clk);
    r0 = 1; e0 = 1;
    for (int k = 0; k <= 760; k++) begin
      #1;
      g = act0(); x = model(C0, k, 1'b1);
      checks++;
      if (g !== x) begin
        failures++;
        $display("FAIL first_line k=%0d got=%h exp=%h", k, g, x);
      end
      if (v0.o_rd) nrd++;
      if (v0.o_newline) nnl++;
      if (v0.o_de) nde++;
      if (v0.o_hsync) nhs++;
      @(negedge clk);
    end
    checks++;
    if (nrd != 640) begin
      failures++;
      $display("FAIL line_rd_count got=%0d exp=640", nrd);
    end
    checks++;
    if (nnl != 1) begin
      failures++;
      $display("FAIL line_newline_count got=%0d exp=1", nnl);
    end
    checks++;
    if (nde != 640) begin
      failures++;
      $display("FAIL line_de_count got=%0d exp=640", nde);
    end
    checks++;
    if (nhs != 96) begin
      failures++;
      $display("FAIL line_hsync_count got=%0d exp=96", nhs);
    end
  endtask

  task automatic test_small_frame();
    logic [45:0] g, x;
    int nrd = 0, nnl = 0, nnf = 0, nhs = 0, nvs = 0;
    @(negedge clk);
    r2 = 1; e2 = 1;
    for (int k = 0; k <= 336; k++) begin
      #1;
      g = act2(); x = model(C2, k, 1'b1);
      checks++;
      if (g !== x) begin
        failures++;
        $display("FAIL small_frame k=%0d got=%h exp=%h", k, g, x);
      end
      checks++;
      if (v2.o_de !== v2.o_rd) begin
        failures++;
        $display("FAIL lead0_de k=%0d got=%b exp=%b",
                 k, v2.o_de, v2.o_rd);
      end
      if (v2.o_rd) nrd++;
      if (v2.o_newline) nnl++;
      if (v2.o_newframe) nnf++;
      if (!v2.o_hsync) nhs++;
      if (!v2.o_vsync) nvs++;
      @(negedge clk);
    end
    checks++;
    if (nrd != 2 * 16 * 4) begin
      failures++;
      $display("FAIL frame_rd_count got=%0d exp=128", nrd);
    end
    checks++;
    if (nnl != 8) begin
      failures++;
      $display("FAIL frame_newline_count got=%0d exp=8", nnl);
    end
    checks++;
    if (nnf != 2) begin
      failures++;
      $display("FAIL frame_newframe_count got=%0d exp=2", nnf);
    end
    checks++;
    if (nhs != 2 * 7 * 3) begin
      failures++;
      $display("FAIL hsync_low_count got=%0d exp=42", nhs);
    end
    checks++;
    if (nvs != 2 * 24) begin
      failures++;
      $display("FAIL vsync_low_count got=%0d exp=48", nvs);
    end
  endtask

  task automatic test_stall();
    logic [45:0] g, x;
    req_t q[$];
    req_t r;
    int n = 0, last = -1, pops = 0, ex = 0, ey = 0, guard = 0;
    @(negedge clk);
    r1 = 1;
    while (n < 341 && guard < 3000) begin
      e1 = ($urandom_range(99, 0) >= 30);
      #1;
      g = act1(); x = model(C1, n, e1);
      checks++;
      if (g !== x) begin
        failures++;
        $display("FAIL stall n=%0d en=%b got=%h exp=%h",
                 n, e1, g, x);
      end
      if (!e1) begin
        checks++;
        if (v1.o_rd !== 1'b0) begin
          failures++;
          $display("FAIL stall_rd n=%0d got=%b exp=0", n, v1.o_rd);
        end
      end
      if (e1 && v1.o_rd)
        q.push_back('{n, int'(v1.o_x), int'(v1.o_y)});
      if (n != last) begin
        last = n;
        if (v1.o_de === 1'b1) begin
          checks++;
          if (q.size() == 0) begin
            failures++;
            $display("FAIL de_no_req n=%0d got=1 exp=0", n);
          end else begin
            r = q.pop_front();
            pops++;
            if (r.n + 4 != n || r.x != ex || r.y != ey) begin
              failures++;
              $display("FAIL de_align n=%0d got=%0d,%0d@%0d exp=%0d,%0d@%0d",
                       n, r.x, r.y, r.n + 4, ex, ey, n);
            end
            ex++;
            if (ex == 16) begin
              ex = 0;
              ey = (ey + 1) % 4;
            end
          end
        end
      end
      if (e1) n++;
      guard++;
      @(negedge clk);
    end
    e1 = 1;
    checks++;
    if (n < 341) begin
      failures++;
      $display("FAIL stall_timeout got=%0d exp=341", n);
    end
    checks++;
    if (pops != 128) begin
      failures++;
      $display("FAIL stall_de_count got=%0d exp=128", pops);
    end
  endtask

  task automatic test_reset_mid();
    logic [45:0] g, x;
    @(negedge clk);
    r0 = 0;
    @(negedge clk);
    r0 = 1; e0 = 1;
    repeat (1101) @(negedge clk);
    #1;
    g = act0(); x = model(C0, 1101, 1'b1);
    checks++;
    if (g !== x || v0.o_x !== 12'd300 || v0.o_y !== 12'd1) begin
      failures++;
      $display("FAIL pre_reset_d0 got=%h exp=%h", g, x);
    end
    #2;
    r0 = 0;
    #1;
    g = act0(); x = model(C0, 0, 1'b1);
    checks++;
    if (g !== x) begin
      failures++;
      $display("FAIL async_reset_d0 got=%h exp=%h", g, x);
    end
    @(negedge clk);
    r0 = 1;
    @(negedge clk);
    #1;
    g = act0(); x = model(C0, 1, 1'b1);
    checks++;
    if (g !== x) begin
      failures++;
      $display("FAIL restart_d0 got=%h exp=%h", g, x);
    end
    @(negedge clk);
    r2 = 0;
    @(negedge clk);
    r2 = 1; e2 = 1;
    repeat (200) @(negedge clk);
    #1;
    g = act2(); x = model(C2, 200, 1'b1);
    checks++;
    if (g !== x || v2.o_frame !== 16'd1) begin
      failures++;
      $display("FAIL pre_reset_d2 got=%h exp=%h", g, x);
    end
    #2;
    r2 = 0;
    #1;
    g = act2(); x = model(C2, 0, 1'b1);
    checks++;
    if (g !== x) begin
      failures++;
      $display("FAIL async_reset_d2 got=%h exp=%h", g, x);
    end
    @(negedge clk);
    r2 = 1;
    @(negedge clk);
    #1;
    g = act2(); x = model(C2, 1, 1'b1);
    checks++;
    if (g !== x) begin
      failures++;
      $display("FAIL restart_d2 got=%h exp=%h", g, x);
    end
  endtask

  task automatic test_frame_wrap();
    logic [45:0] g, x;
    int guard = 0;
    while (n3 < 65536 && guard < 70000) begin
      @(negedge clk);
      guard++;
    end
    #1;
    checks++;
    if (n3 != 65536) begin
      failures++;
      $display("FAIL wrap_timeout got=%0d exp=65536", n3);
    end else begin
      g = act3(); x = model(C3, 65536, 1'b1);
      checks++;
      if (g !== x || v3.o_frame !== 16'hffff) begin
        failures++;
        $display("FAIL wrap_pre got=%h exp=%h", g, x);
      end
      @(negedge clk);
      #1;
      g = act3(); x = model(C3, 65537, 1'b1);
      checks++;
      if (g !== x || v3.o_frame !== 16'h0000) begin
        failures++;
        $display("FAIL wrap_post got=%h exp=%h", g, x);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_small_frame();
    test_stall();
    test_reset_mid();
    test_frame_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
